ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
Single-clock read-side engine for our synchronous-read RAM blocks. It accepts a burst command (start address, word count), drives the RAM read address, absorbs the RAM's 1-cycle read latency, and emits words on a valid/ready stream with full backpressure support and a last-beat marker. It sits between a dual-port RAM's read port and a downstream consumer, for example a packetiser or a checker.

Parameters:
DW, 16, RAM read data width and stream data width.
AW, 6, RAM read address width; address space is 2^AW words.
LW, 7, burst length width; must satisfy 2^(LW-1) >= 2^AW so a full-memory burst fits.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  burst command valid.
cmd_ready  out  1  block can accept a command.
cmd_addr  in  AW  first word address.
cmd_len  in  LW  number of words to read; 0 is legal.
rd_en  out  1  read issue strobe, one per address presented.
rd_addr  out  AW  RAM read address.
rd_data  in  DW  RAM read data, valid in the cycle after the edge that sampled rd_addr.
m_valid  out  1  stream data valid.
m_ready  in  1  downstream accepts the beat.
m_data  out  DW  stream data.
m_last  out  1  marks the final beat of the burst.
busy  out  1  a burst is in progress (state != IDLE).
done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset, asynchronous, active-high. All of the following go to 0 immediately: state=IDLE, rd_en, rd_addr, m_valid, m_data, m_last, busy, done. cmd_ready is 1 once in IDLE. In-flight reads are discarded. Reset mid-burst aborts the burst with no done pulse.
- RAM timing contract. Address presented during cycle N with rd_en=1 is sampled at the end of N. Data is valid on rd_data during N+1 and is captured into the output buffer at the end of N+1.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len. len>0 goes to ISSUE. len=0 stays in IDLE and pulses done in the next cycle; no reads, no beats.
  - ISSUE: cmd_ready=0. Issue reads while issue_cnt < len. rd_addr = base + issue_cnt, modulo 2^AW, so 2^AW-1 wraps to 0. When the final read issues, go to DRAIN.
  - DRAIN: wait until the last beat handshakes (m_valid&m_ready&m_last), then go to IDLE with done=1 for exactly one cycle in the following cycle.
- Output buffer:
  - 2-entry FIFO; head drives m_data/m_valid.
  - Credit rule: rd_en = (state==ISSUE) && (fifo_count + inflight - pop < 2), where inflight is a read issued last cycle and pop = m_valid&m_ready.
  - The FIFO never overflows. Simultaneous push and pop keep the count unchanged.
- rd_addr holds its last value when rd_en=0.
- Stream rules:
  - m_data and m_last are stable while m_valid&!m_ready.
  - m_valid never drops without a handshake.
  - m_last=1 only on beat index len-1.
- Latency: cmd accepted at edge E0, rd_en=1 in the cycle after E0, m_valid=1 two cycles after E0.
- Throughput: with m_ready held at 1, one beat per cycle. A burst of L words completes its last handshake L+1 cycles after acceptance.
- Counters:
  - issue_cnt and beat_cnt are LW bits.
  - Beat index len-1 identifies last.
  - Address arithmetic truncates to AW bits.
- cmd_valid is ignored outside IDLE. A command presented during done's cycle is accepted, since state is IDLE then.

Test Plan:
- Bench: 1-cycle synchronous-read RAM model preloaded with mem[i]=i*16'h0101 (DW=16, AW=6).
- Basic burst: cmd_addr=5, cmd_len=4, m_ready=1 -> m_valid first high 2 cycles after accept; beats 0x0505, 0x0606, 0x0707, 0x0808 on consecutive cycles; m_last only on 0x0808; single done pulse the cycle after.
- Wrap-around: cmd_addr=62, cmd_len=4 -> rd_addr sequence 62, 63, 0, 1; data 0x3E3E, 0x3F3F, 0x0000, 0x0101.
- Backpressure: cmd_addr=0, cmd_len=8, m_ready toggling 1,0,0,1,0,1... -> all 8 beats in order with no loss or duplication; m_data stable while stalled; rd_en never issued with FIFO+inflight at 2.
- Zero length and back-to-back:
  - cmd_len=0 -> no rd_en, no m_valid, done one cycle after accept.
  - Then cmd_addr=10, cmd_len=2 presented during done -> accepted; beats 0x0A0A, 0x0B0B.
- Full memory: cmd_addr=0, cmd_len=64, m_ready=1 -> 64 beats, last handshake 65 cycles after accept, m_last on 0x3F3F.
- Reset mid-burst: assert rst after 3 of 8 beats -> all outputs 0 immediately; no further beats, no done; a new command afterwards runs cleanly from its own address.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: bundles the command, RAM read port and output stream of ram_stream_reader
//   master: the reader side (drives cmd_ready, rd_en/rd_addr, m_valid/m_data/m_last, busy, done)
//   slave : the environment side (drives cmd_valid/cmd_addr/cmd_len, rd_data, m_ready)
interface ram_stream_reader_if #(
  parameter int DW = 16,
  parameter int AW = 6,
  parameter int LW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rd_data, m_ready,
    output cmd_ready, rd_en, rd_addr, m_valid, m_data, m_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rd_data, m_ready,
    input  cmd_ready, rd_en, rd_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader for a 1-cycle synchronous-read RAM, emitting a valid/ready stream
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command (cmd_*), RAM read port (rd_*), stream (m_*), busy and done pulse
module ram_stream_reader #(
  parameter int DW = 16,
  parameter int AW = 6,
  parameter int LW = 7
) (
  input logic clk,
  input logic rst,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t        state, state_nx;
  logic [AW-1:0] base, addr_q;
  logic [LW-1:0] len, issue_cnt, beat_cnt;
  logic          inflight, done_q, accept, issue, pop, last_beat;
  logic [DW-1:0] fifo [2];
  logic          wptr, rptr;
  logic [1:0]    count;
  logic [2:0]    occ;
  assign pop       = bus.m_valid & bus.m_ready;
  assign last_beat = pop & bus.m_last;
  assign accept    = bus.cmd_ready & bus.cmd_valid;
  // buffer slots already spoken for: stored words plus the read whose data lands this cycle
  assign occ   = {1'b0, count} + {2'b0, inflight};
  // a beat leaving this cycle frees a slot, so one more read may be issued
  assign issue = state == ISSUE && occ < (pop ? 3'd3 : 3'd2);
  assign bus.cmd_ready = state == IDLE;
  assign bus.rd_en     = issue;
  // between issues the address holds the last one presented
  assign bus.rd_addr   = issue ? base + AW'(issue_cnt) : addr_q;
  assign bus.m_valid   = count != 2'd0;
  assign bus.m_data    = fifo[rptr];
  assign bus.m_last    = bus.m_valid && beat_cnt == len - LW'(1);
  assign bus.busy      = state != IDLE;
  assign bus.done      = done_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept && bus.cmd_len != '0) state_nx = ISSUE;
    else if (issue && issue_cnt + LW'(1) == len) state_nx = DRAIN;
    else if (state == DRAIN && last_beat) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base      <= '0;
      len       <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      addr_q    <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      count     <= '0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      inflight <= issue;
      done_q   <= (accept && bus.cmd_len == '0) || (state == DRAIN && last_beat);
      if (accept) begin
        base      <= bus.cmd_addr;
        len       <= bus.cmd_len;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end
      if (issue) begin
        issue_cnt <= issue_cnt + LW'(1);
        addr_q    <= bus.rd_addr;
      end
      if (inflight) begin
        fifo[wptr] <= bus.rd_data;
        wptr       <= ~wptr;
      end
      if (pop) begin
        rptr     <= ~rptr;
        beat_cnt <= beat_cnt + LW'(1);
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed burst vectors against a 1-cycle synchronous-read RAM model
module tb_ram_stream_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] mem [64];
  bit   rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  typedef struct {
    logic [5:0]  addr;
    logic [6:0]  len;
    bit          bp;
    logic [15:0] last;
    int          lat;
  } vec_t;
  vec_t tv [5];
  ram_stream_reader_if #(.DW(16), .AW(6), .LW(7)) bus ();
  ram_stream_reader #(.DW(16), .AW(6), .LW(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_idle_zero(input string nm);
    chk({nm, "_rd_en"}, bus.rd_en, 0);
    chk({nm, "_rd_addr"}, bus.rd_addr, 0);
    chk({nm, "_m_valid"}, bus.m_valid, 0);
    chk({nm, "_m_data"}, bus.m_data, 0);
    chk({nm, "_m_last"}, bus.m_last, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask
  // called just after a posedge; presents the command, follows the burst to its done pulse
  task automatic burst(input logic [5:0] a, input logic [6:0] l, input bit bp,
                       input logic [15:0] lastd, input int lat, input bit dn);
    int beats = 0, issued = 0, occ = 0, infl = 0;
    bit fin = 0, seen = 0, stall = 0, pop;
    logic [15:0] hd = '0;
    logic hl = 1'b0;
    logic [5:0] ea;
    #1 bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l; bus.m_ready = 1'b1;
    @(negedge clk);
    chk("cmd_ready", bus.cmd_ready, 1);
    chk("done_at_cmd", bus.done, dn);
    chk("rd_en_idle", bus.rd_en, 0);
    chk("m_valid_idle", bus.m_valid, 0);
    @(posedge clk);
    for (int c = 0; c < 300 && !fin; c++) begin
      #1 bus.cmd_valid = 1'b0; bus.m_ready = bp ? rdy_pat[c % 6] : 1'b1;
      @(negedge clk);
      pop = bus.m_valid & bus.m_ready;
      if (c == 0) begin
        chk("busy_c0", bus.busy, 1);
        chk("done_c0", bus.done, 0);
        chk("rd_en_c0", bus.rd_en, 1);
      end
      if (stall) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, hd);
        chk("hold_last", bus.m_last, hl);
      end
      if (bus.rd_en) begin
        ea = a + 6'(issued);
        chk("rd_addr", bus.rd_addr, ea);
        chk("credit", (occ + infl - int'(pop)) < 2, 1);
        issued++;
      end
      if (bus.m_valid && !seen) begin
        seen = 1;
        chk("first_valid_cycle", c, 2);
      end
      if (pop) begin
        ea = a + 6'(beats);
        chk("m_data", bus.m_data, {2'b0, ea, 2'b0, ea});
        chk("m_last", bus.m_last, beats == l - 1);
        beats++;
        if (bus.m_last) begin
          fin = 1;
          chk("last_data", bus.m_data, lastd);
          if (lat >= 0) chk("last_cycle", c, lat);
        end
      end
      stall = bus.m_valid & ~bus.m_ready;
      hd = bus.m_data;
      hl = bus.m_last;
      occ = occ + infl - int'(pop);
      infl = bus.rd_en;
      if (!fin) @(posedge clk);
    end
    chk("beats", beats, l);
    chk("issued", issued, l);
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("busy_after", bus.busy, 0);
    chk("m_valid_after", bus.m_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i) * 16'h0101;
    tv[0] = '{addr: 6'd5,  len: 7'd4,  bp: 1'b0, last: 16'h0808, lat: 5};
    tv[1] = '{addr: 6'd62, len: 7'd4,  bp: 1'b0, last: 16'h0101, lat: 5};
    tv[2] = '{addr: 6'd0,  len: 7'd8,  bp: 1'b1, last: 16'h0707, lat: -1};
    tv[3] = '{addr: 6'd0,  len: 7'd64, bp: 1'b0, last: 16'h3F3F, lat: 65};
    tv[4] = '{addr: 6'd33, len: 7'd1,  bp: 1'b0, last: 16'h2121, lat: 2};
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (tv[i]) begin
      @(posedge clk);
      burst(tv[i].addr, tv[i].len, tv[i].bp, tv[i].last, tv[i].lat, 1'b0);
    end
    // zero-length command, then a new command presented in its done cycle
    @(posedge clk);
    #1 bus.cmd_valid = 1'b1; bus.cmd_addr = 6'd7; bus.cmd_len = 7'd0;
    @(negedge clk);
    chk("zero_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    burst(6'd10, 7'd2, 1'b0, 16'h0B0B, 3, 1'b1);
    // reset after three beats of an eight-beat burst
    @(posedge clk);
    #1 bus.cmd_valid = 1'b1; bus.cmd_addr = 6'd0; bus.cmd_len = 7'd8; bus.m_ready = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) n++;
      @(posedge clk);
    end
    chk("beats_before_reset", n, 3);
    #1 rst = 1'b1;
    #1 chk_idle_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_reset_m_valid", bus.m_valid, 0);
      chk("post_reset_done", bus.done, 0);
      chk("post_reset_rd_en", bus.rd_en, 0);
    end
    @(posedge clk);
    burst(6'd20, 7'd3, 1'b0, 16'h1616, 4, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
